seg_display_scan: RTL and testbench



---
 rtl/seg_display_scan.sv | 115 +++++++++++
 tb/tb_seg_display_scan.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// rtl/seg_display_scan.sv - 4-digit multiplexed active-low seven-segment driver
// Latches a hex value plus blank/blink/dp masks and scans digits with a per-slot guard.
module seg_display_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic        load,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] GUARD_CNT  = SW'(GUARD);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [15:0]   data;
  logic [3:0]    blank_r;
  logic [3:0]    blink_r;
  logic [3:0]    dp_r;
  logic [SW-1:0] slot_cnt;
  logic [1:0]    idx;
  logic [FW-1:0] frame_cnt;
  logic          phase;

  logic [3:0] nibble;
  logic       visible;
  logic [6:0] seg_code;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0: hex_decode = 7'h40;
      4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;
      4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;
      4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;
      4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;
      4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;
      4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;
      4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;
      default: hex_decode = 7'h0E;
    endcase
  endfunction

  always_comb begin
    nibble   = data[{idx, 2'b00} +: 4];
    seg_code = hex_decode(nibble);
    visible  = (slot_cnt >= GUARD_CNT) && !blank_r[idx] && !(blink_r[idx] && phase);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      blank_r   <= '0;
      blink_r   <= '0;
      dp_r      <= '0;
      slot_cnt  <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      phase     <= 1'b0;
      an        <= 4'b1111;
      seg       <= 7'h7F;
      dp        <= 1'b1;
    end else begin
      if (load) begin
        data    <= digits_in;
        blank_r <= blank_mask;
        blink_r <= blink_mask;
        dp_r    <= dp_mask;
      end

      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        idx      <= idx + 2'd1;
        if (idx == 2'd3) begin
          if (frame_cnt == FRAME_LAST) begin
            frame_cnt <= '0;
            phase     <= ~phase;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      // Pins reflect pre-edge state, giving a fixed one-cycle latency.
      if (visible) begin
        an  <= ~(4'b0001 << idx);
        seg <= seg_code;
        dp  <= ~dp_r[idx];
      end else begin
        an  <= 4'b1111;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// tb/tb_seg_display_scan.sv - scoreboard bench for seg_display_scan
// Expected pins come from elapsed-time arithmetic over the latched inputs.
module tb_seg_display_scan;
  localparam int RD = 8;
  localparam int G  = 2;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = '0;
  logic        load = 1'b0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  dp_mask = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  seg_display_scan #(.REFRESH_DIV(RD), .GUARD(G), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .load(load),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .dp_mask(dp_mask),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [15:0] m_data;
  logic [3:0]  m_blank, m_blink, m_dp;
  int          e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // e = clock edges already seen since reset release
  function automatic exp_t model(input int el);
    exp_t r;
    int slot, di, ph;
    logic [3:0] nib;
    slot = el % RD;
    di   = (el / RD) % 4;
    ph   = (el / (4 * RD * BF)) % 2;
    nib  = 4'((m_data >> (4 * di)) & 16'hF);
    if (slot >= G && !m_blank[di] && !(m_blink[di] && ph == 1)) begin
      r.an  = 4'hF & ~(4'b0001 << di);
      r.seg = hex_tab[nib];
      r.dp  = ~m_dp[di];
    end else begin
      r.an  = 4'b1111;
      r.seg = 7'h7F;
      r.dp  = 1'b1;
    end
    return r;
  endfunction

  task automatic step(input logic ld, input logic [15:0] d,
                      input logic [3:0] bl, input logic [3:0] bk, input logic [3:0] dpm);
    @(negedge clk);
    load = ld; digits_in = d; blank_mask = bl; blink_mask = bk; dp_mask = dpm;
    q.push_back(model(e));
    if (ld) begin
      m_data = d; m_blank = bl; m_blink = bk; m_dp = dpm;
    end
    e++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic release_rst;
    @(posedge clk);
    #3;
    rst = 1'b0;
    m_data = '0; m_blank = '0; m_blink = '0; m_dp = '0;
    e = 0;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("an", 32'(an), 32'(x.an));
        chk("seg", 32'(seg), 32'(x.seg));
        chk("dp", 32'(dp), 32'(x.dp));
        chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
      end
    end
  end

  initial begin : stim
    logic [15:0] sweep [4];
    sweep[0] = 16'h0123; sweep[1] = 16'h4567; sweep[2] = 16'h89AB; sweep[3] = 16'hCDEF;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);

    release_rst();
    idle(4 * RD);

    foreach (sweep[i]) begin
      step(1'b1, sweep[i], 4'h0, 4'h0, 4'h0);
      idle(4 * RD);
    end

    step(1'b1, 16'hA5C3, 4'b0010, 4'b0000, 4'b0001);
    idle(8 * RD);

    step(1'b1, 16'h1234, 4'b0000, 4'b1000, 4'b0000);
    idle(4 * 4 * RD * BF + 10);

    while ((e % (4 * RD)) != 4) idle(1);
    step(1'b1, 16'h000F, 4'h0, 4'h0, 4'h0);
    idle(4 * RD);

    // held load: every cycle re-latches, last value wins
    for (int i = 0; i < 5; i++)
      step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    idle(4 * RD);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0)
        step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      else
        step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end

    // async reset mid-slot, no clock edge needed
    @(posedge clk);
    #3;
    rst = 1'b1;
    q.delete();
    #1;
    chk("async_rst_an", 32'(an), 32'hF);
    chk("async_rst_seg", 32'(seg), 32'h7F);
    chk("async_rst_dp", 32'(dp), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    chk("held_rst_an", 32'(an), 32'hF);

    release_rst();
    idle(3 * 4 * RD);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
